// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared types and constants for the cursor tracker
package cursor_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // bit positions inside the PS/2 status byte
   localparam int BTN_L = 0;
   localparam int BTN_R = 1;
   localparam int BTN_M = 2;
   localparam int SGN_X = 4;
   localparam int SGN_Y = 5;
   localparam int OVF_X = 6;
   localparam int OVF_Y = 7;

   // deltas at or above this magnitude are doubled when acceleration is built in
   localparam int ACCEL_THRESH = 16;

   typedef logic signed [9:0] delta_t;

endpackage

// File: rtl/cursor_axis.sv
// rtl/cursor_axis.sv - one cursor axis: delta decode, sub-pixel accumulate, clamp (CURSOR_ACCEL_EN adds acceleration)
module cursor_axis
   import cursor_pkg::*;
#(
   parameter int POS_W     = 10,
   parameter int MIN       = 105,
   parameter int MAX       = 535,
   parameter int HOME      = 105,
   parameter int FRAC_BITS = 0,
   parameter bit INVERT    = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             recenter,
   input  logic             load,
   input  logic             apply,
   input  logic             sgn,
   input  logic             ovf,
   input  logic [7:0]       mag,
   output logic [POS_W-1:0] pos,
   output logic             changed
);

   localparam int ACC_W = POS_W + 3;
   localparam logic [2:0] RES_MASK = 3'((1 << FRAC_BITS) - 1);
   localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(MIN);
   localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX);
   localparam logic [POS_W-1:0] MIN_P  = POS_W'(MIN);
   localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX);
   localparam logic [POS_W-1:0] HOME_P = POS_W'(HOME);
   localparam delta_t D_POS_SAT = delta_t'(255);
   localparam delta_t D_NEG_SAT = delta_t'(-256);
   localparam delta_t D_MOST_POS = delta_t'(511);
   localparam delta_t D_MOST_NEG = delta_t'(-512);

   delta_t raw;
   delta_t scaled;
   delta_t delta_d;
   delta_t delta_q;
   logic [2:0] residual;
   logic [2:0] res_next;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] step;
   logic signed [ACC_W-1:0] sum;
   logic [POS_W-1:0] pos_next;
   logic hit_lo;
   logic hit_hi;

`ifdef CURSOR_ACCEL_EN
   localparam delta_t THRESH_P = delta_t'(ACCEL_THRESH);
   logic signed [10:0] dbl;

   // turn the 9-bit packet delta into a signed 10-bit, saturated, accelerated, optionally negated value
   always_comb begin
      raw = $signed({sgn, sgn, mag});
      if (ovf) raw = sgn ? D_NEG_SAT : D_POS_SAT;
      dbl = $signed({raw, 1'b0});
      scaled = raw;
      if (raw >= THRESH_P || raw <= -THRESH_P) begin
         if (dbl > 11'sd511)       scaled = D_MOST_POS;
         else if (dbl < -11'sd512) scaled = D_MOST_NEG;
         else                      scaled = $signed(dbl[9:0]);
      end
      delta_d = scaled;
      // negating -512 would wrap, so it saturates to the most positive value
      if (INVERT) delta_d = (scaled == D_MOST_NEG) ? D_MOST_POS : -scaled;
   end
`else
   // turn the 9-bit packet delta into a signed 10-bit, saturated, optionally negated value
   always_comb begin
      raw = $signed({sgn, sgn, mag});
      if (ovf) raw = sgn ? D_NEG_SAT : D_POS_SAT;
      scaled = raw;
      delta_d = scaled;
      if (INVERT) delta_d = (scaled == D_MOST_NEG) ? D_MOST_POS : -scaled;
   end
`endif

   // add the carried sub-pixel remainder, take the whole-pixel step and clamp to the window
   always_comb begin
      acc = $signed({{(ACC_W-4){1'b0}}, 1'b0, residual})
          + $signed({{(ACC_W-10){delta_q[9]}}, delta_q});
      step = acc >>> FRAC_BITS;
      sum = $signed({3'b000, pos}) + step;
      hit_lo = sum < MIN_S;
      hit_hi = sum > MAX_S;
      pos_next = sum[POS_W-1:0];
      res_next = acc[2:0] & RES_MASK;
      if (hit_lo) begin
         pos_next = MIN_P;
         res_next = 3'd0;
      end else if (hit_hi) begin
         pos_next = MAX_P;
         res_next = 3'd0;
      end
      changed = (pos_next != pos);
   end

   // delta register loads in DECODE, position/remainder commit in UPDATE; recenter wins over both
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pos      <= HOME_P;
         residual <= 3'd0;
         delta_q  <= '0;
      end else if (recenter) begin
         pos      <= HOME_P;
         residual <= 3'd0;
      end else begin
         if (load) delta_q <= delta_d;
         if (apply) begin
            pos      <= pos_next;
            residual <= res_next;
         end
      end
   end

endmodule

// File: rtl/cursor_tracker.sv
// rtl/cursor_tracker.sv - PS/2 packet to clamped cursor position and buttons (CURSOR_ACCEL_EN enables acceleration)
module cursor_tracker
   import cursor_pkg::*;
#(
   parameter int POS_W     = 10,
   parameter int X_MIN     = 105,
   parameter int X_MAX     = 535,
   parameter int Y_MIN     = 105,
   parameter int Y_MAX     = 375,
   parameter int X_HOME    = 105,
   parameter int Y_HOME    = 105,
   parameter int FRAC_BITS = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             pkt_valid,
   output logic             pkt_ready,
   input  logic [7:0]       byte1,
   input  logic [7:0]       byte2,
   input  logic [7:0]       byte3,
   input  logic             recenter,
   output logic [POS_W-1:0] cursorX,
   output logic [POS_W-1:0] cursorY,
   output logic             leftButton,
   output logic             middleButton,
   output logic             rightButton,
   output logic [2:0]       btn_press,
   output logic [2:0]       btn_release,
   output logic             moved
);

   state_t state;
   logic [7:0] stat_q;
   logic [7:0] dy_q;
   logic [7:0] dx_q;
   logic [2:0] btn;
   logic [2:0] btn_new;
   logic load;
   logic apply;
   logic x_changed;
   logic y_changed;
   logic unused_sync_bit;

   // status bit 3 is the PS/2 always-one framing bit and carries no information
   assign unused_sync_bit = stat_q[3];

   assign pkt_ready = (state == IDLE) && !recenter;
   assign load      = (state == DECODE) && !recenter;
   assign apply     = (state == UPDATE) && !recenter;
   assign btn_new   = {stat_q[BTN_M], stat_q[BTN_R], stat_q[BTN_L]};

   assign leftButton   = btn[0];
   assign rightButton  = btn[1];
   assign middleButton = btn[2];

   cursor_axis #(
      .POS_W(POS_W), .MIN(X_MIN), .MAX(X_MAX), .HOME(X_HOME),
      .FRAC_BITS(FRAC_BITS), .INVERT(1'b0)
   ) u_x (
      .Clk(Clk), .Reset(Reset), .recenter(recenter), .load(load), .apply(apply),
      .sgn(stat_q[SGN_X]), .ovf(stat_q[OVF_X]), .mag(dx_q),
      .pos(cursorX), .changed(x_changed)
   );

   // screen Y grows downward, so the mouse Y delta is negated
   cursor_axis #(
      .POS_W(POS_W), .MIN(Y_MIN), .MAX(Y_MAX), .HOME(Y_HOME),
      .FRAC_BITS(FRAC_BITS), .INVERT(1'b1)
   ) u_y (
      .Clk(Clk), .Reset(Reset), .recenter(recenter), .load(load), .apply(apply),
      .sgn(stat_q[SGN_Y]), .ovf(stat_q[OVF_Y]), .mag(dy_q),
      .pos(cursorY), .changed(y_changed)
   );

   // packet FSM: capture, decode, commit; buttons and one-cycle pulses are registered on commit
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         stat_q      <= 8'd0;
         dy_q        <= 8'd0;
         dx_q        <= 8'd0;
         btn         <= 3'd0;
         btn_press   <= 3'd0;
         btn_release <= 3'd0;
         moved       <= 1'b0;
      end else begin
         btn_press   <= 3'd0;
         btn_release <= 3'd0;
         moved       <= 1'b0;
         if (recenter) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (pkt_valid) begin
                     stat_q <= byte1;
                     dy_q   <= byte2;
                     dx_q   <= byte3;
                     state  <= DECODE;
                  end
               end
               DECODE: state <= UPDATE;
               UPDATE: begin
                  btn         <= btn_new;
                  btn_press   <= btn_new & ~btn;
                  btn_release <= btn & ~btn_new;
                  moved       <= x_changed | y_changed;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cursor_tracker.sv
// tb/tb_cursor_tracker.sv - self-checking bench for cursor_tracker (honours CURSOR_ACCEL_EN)
module tb_cursor_tracker;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic pkt_valid = 1'b0;
   logic recenter = 1'b0;
   logic [7:0] byte1 = 8'h08;
   logic [7:0] byte2 = 8'h00;
   logic [7:0] byte3 = 8'h00;

   // index 0: FRAC_BITS=0 instance, index 1: FRAC_BITS=2 instance
   logic rdy[2];
   logic [9:0] cx[2];
   logic [9:0] cy[2];
   logic lb[2];
   logic mb[2];
   logic rb[2];
   logic [2:0] bp[2];
   logic [2:0] br[2];
   logic mv[2];

   int n_cmp = 0;
   int n_bad = 0;

   cursor_tracker u_lin (
      .Clk(Clk), .Reset(Reset), .pkt_valid(pkt_valid), .pkt_ready(rdy[0]),
      .byte1(byte1), .byte2(byte2), .byte3(byte3), .recenter(recenter),
      .cursorX(cx[0]), .cursorY(cy[0]), .leftButton(lb[0]), .middleButton(mb[0]),
      .rightButton(rb[0]), .btn_press(bp[0]), .btn_release(br[0]), .moved(mv[0])
   );

   cursor_tracker #(.FRAC_BITS(2)) u_frac (
      .Clk(Clk), .Reset(Reset), .pkt_valid(pkt_valid), .pkt_ready(rdy[1]),
      .byte1(byte1), .byte2(byte2), .byte3(byte3), .recenter(recenter),
      .cursorX(cx[1]), .cursorY(cy[1]), .leftButton(lb[1]), .middleButton(mb[1]),
      .rightButton(rb[1]), .btn_press(bp[1]), .btn_release(br[1]), .moved(mv[1])
   );

   always #5 Clk = ~Clk;

   // reference model state
   int mx[2];
   int my[2];
   int rx[2];
   int ry[2];
   logic [2:0] mbtn;
   logic [2:0] mpress;
   logic [2:0] mrel;
   logic mmoved[2];

   typedef struct {
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] b3;
      int x;
      int y;
      logic mv;
      logic [2:0] btn;
      logic [2:0] prs;
      logic [2:0] rel;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int frac_of(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   function automatic int decode(input bit sgn, input bit ovf, input logic [7:0] mag, input bit inv);
      int d;
      if (ovf) d = sgn ? -256 : 255;
      else     d = sgn ? int'(mag) - 256 : int'(mag);
`ifdef CURSOR_ACCEL_EN
      if (d >= 16 || d <= -16) begin
         d = 2 * d;
         if (d > 511) d = 511;
         if (d < -512) d = -512;
      end
`endif
      if (inv) begin
         d = -d;
         if (d > 511) d = 511;
      end
      return d;
   endfunction

   function automatic int floor_div(input int a, input int d);
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   task automatic model_axis(input int pos, input int res, input int delta, input int f,
                             input int lo, input int hi, output int np, output int nr);
      int d;
      int acc;
      int st;
      d = 1 << f;
      acc = res + delta;
      st = floor_div(acc, d);
      np = pos + st;
      nr = acc - st * d;
      if (np > hi) begin
         np = hi;
         nr = 0;
      end else if (np < lo) begin
         np = lo;
         nr = 0;
      end
   endtask

   task automatic model_home();
      for (int k = 0; k < 2; k++) begin
         mx[k] = 105;
         my[k] = 105;
         rx[k] = 0;
         ry[k] = 0;
      end
   endtask

   task automatic model_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      int dx;
      int dy;
      int nx;
      int ny;
      int nrx;
      int nry;
      logic [2:0] nb;
      dx = decode(b1[4], b1[6], b3, 1'b0);
      dy = decode(b1[5], b1[7], b2, 1'b1);
      for (int k = 0; k < 2; k++) begin
         model_axis(mx[k], rx[k], dx, frac_of(k), 105, 535, nx, nrx);
         model_axis(my[k], ry[k], dy, frac_of(k), 105, 375, ny, nry);
         mmoved[k] = (nx != mx[k]) || (ny != my[k]);
         mx[k] = nx;
         my[k] = ny;
         rx[k] = nrx;
         ry[k] = nry;
      end
      nb = {b1[2], b1[1], b1[0]};
      mpress = nb & ~mbtn;
      mrel = mbtn & ~nb;
      mbtn = nb;
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("x_inst%0d", k), cx[k], mx[k]);
         chk($sformatf("y_inst%0d", k), cy[k], my[k]);
         chk($sformatf("moved_inst%0d", k), mv[k], mmoved[k]);
         chk($sformatf("buttons_inst%0d", k), {mb[k], rb[k], lb[k]}, mbtn);
         chk($sformatf("press_inst%0d", k), bp[k], mpress);
         chk($sformatf("release_inst%0d", k), br[k], mrel);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (rdy[0] !== 1'b1 && n < 10) begin
         @(posedge Clk);
         @(negedge Clk);
         n++;
      end
      chk("ready_before_send", rdy[0], 1);
   endtask

   // called at a falling edge; returns at the falling edge after the commit edge
   task automatic send(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      int ox[2];
      wait_ready();
      for (int k = 0; k < 2; k++) ox[k] = mx[k];
      byte1 = b1;
      byte2 = b2;
      byte3 = b3;
      pkt_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      pkt_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ready_busy1_inst%0d", k), rdy[k], 0);
         chk($sformatf("moved_clear_inst%0d", k), mv[k], 0);
         chk($sformatf("press_clear_inst%0d", k), bp[k], 0);
         chk($sformatf("release_clear_inst%0d", k), br[k], 0);
      end
      @(posedge Clk);
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ready_busy2_inst%0d", k), rdy[k], 0);
         chk($sformatf("x_not_early_inst%0d", k), cx[k], ox[k]);
      end
      @(posedge Clk);
      @(negedge Clk);
      model_packet(b1, b2, b3);
      check_model();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[15];
      logic [7:0] r1;
      logic [7:0] r2;
      logic [7:0] r3;

      tbl[0]  = '{8'h08, 8'h00, 8'h0A, 115, 105, 1'b1, 3'b000, 3'b000, 3'b000};
      tbl[1]  = '{8'h18, 8'h00, 8'hF6, 105, 105, 1'b1, 3'b000, 3'b000, 3'b000};
      tbl[2]  = '{8'h18, 8'h00, 8'hF6, 105, 105, 1'b0, 3'b000, 3'b000, 3'b000};
      tbl[3]  = '{8'h28, 8'hEC, 8'h00, 105, 125, 1'b1, 3'b000, 3'b000, 3'b000};
      tbl[4]  = '{8'h48, 8'h00, 8'h00, 360, 125, 1'b1, 3'b000, 3'b000, 3'b000};
      tbl[5]  = '{8'h48, 8'h00, 8'h00, 535, 125, 1'b1, 3'b000, 3'b000, 3'b000};
      tbl[6]  = '{8'h48, 8'h00, 8'h00, 535, 125, 1'b0, 3'b000, 3'b000, 3'b000};
      tbl[7]  = '{8'h09, 8'h00, 8'h00, 535, 125, 1'b0, 3'b001, 3'b001, 3'b000};
      tbl[8]  = '{8'h08, 8'h00, 8'h00, 535, 125, 1'b0, 3'b000, 3'b000, 3'b001};
      tbl[9]  = '{8'h0E, 8'h00, 8'h00, 535, 125, 1'b0, 3'b110, 3'b110, 3'b000};
      tbl[10] = '{8'h0C, 8'h00, 8'h00, 535, 125, 1'b0, 3'b100, 3'b000, 3'b010};
      tbl[11] = '{8'h88, 8'h00, 8'h00, 535, 105, 1'b1, 3'b000, 3'b000, 3'b100};
      tbl[12] = '{8'h28, 8'h80, 8'h00, 535, 233, 1'b1, 3'b000, 3'b000, 3'b000};
      tbl[13] = '{8'h38, 8'h00, 8'h9C, 435, 375, 1'b1, 3'b000, 3'b000, 3'b000};
      tbl[14] = '{8'h08, 8'h01, 8'h01, 436, 374, 1'b1, 3'b000, 3'b000, 3'b000};

      // reset values
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_x_inst%0d", k), cx[k], 105);
         chk($sformatf("rst_y_inst%0d", k), cy[k], 105);
         chk($sformatf("rst_buttons_inst%0d", k), {mb[k], rb[k], lb[k]}, 0);
         chk($sformatf("rst_pulses_inst%0d", k), {bp[k], br[k], mv[k]}, 0);
      end
      Reset = 1'b0;
      #1;
      chk("ready_after_reset", rdy[0], 1);
      model_home();
      mbtn = 3'b000;
      @(negedge Clk);

`ifndef CURSOR_ACCEL_EN
      for (int i = 0; i < 15; i++) begin
         send(tbl[i].b1, tbl[i].b2, tbl[i].b3);
         chk($sformatf("tbl%0d_x", i), cx[0], tbl[i].x);
         chk($sformatf("tbl%0d_y", i), cy[0], tbl[i].y);
         chk($sformatf("tbl%0d_moved", i), mv[0], tbl[i].mv);
         chk($sformatf("tbl%0d_buttons", i), {mb[0], rb[0], lb[0]}, tbl[i].btn);
         chk($sformatf("tbl%0d_press", i), bp[0], tbl[i].prs);
         chk($sformatf("tbl%0d_release", i), br[0], tbl[i].rel);
      end
`else
      send(8'h08, 8'h00, 8'h14);
      chk("accel_dx20", cx[0], 145);
      send(8'h08, 8'h00, 8'h0F);
      chk("accel_dx15", cx[0], 160);
`endif

      // recenter held for two cycles: home position, no acceptance
      recenter = 1'b1;
      pkt_valid = 1'b1;
      byte1 = 8'h09;
      byte2 = 8'h00;
      byte3 = 8'h05;
      @(posedge Clk);
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rc_x_inst%0d", k), cx[k], 105);
         chk($sformatf("rc_y_inst%0d", k), cy[k], 105);
         chk($sformatf("rc_ready_inst%0d", k), rdy[k], 0);
         chk($sformatf("rc_moved_inst%0d", k), mv[k], 0);
      end
      @(posedge Clk);
      @(negedge Clk);
      chk("rc_ready_held", rdy[0], 0);
      pkt_valid = 1'b0;
      recenter = 1'b0;
      #1;
      chk("rc_ready_released", rdy[0], 1);
      model_home();
      @(negedge Clk);

      // sub-pixel accumulation on the FRAC_BITS=2 instance
      for (int i = 0; i < 4; i++) begin
         send(8'h08, 8'h00, 8'h01);
         chk($sformatf("frac_plus1_step%0d", i), cx[1], (i == 3) ? 106 : 105);
         chk($sformatf("lin_plus1_step%0d", i), cx[0], 106 + i);
      end
      send(8'h18, 8'h00, 8'hFD);
      chk("frac_minus3", cx[1], 105);
      chk("lin_minus3", cx[0], 106);
      send(8'h08, 8'h00, 8'h03);
      chk("frac_residual1_plus3", cx[1], 106);

      // recenter during DECODE drops the packet
      wait_ready();
      byte1 = 8'h09;
      byte2 = 8'h00;
      byte3 = 8'h32;
      pkt_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      pkt_valid = 1'b0;
      recenter = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      chk("drop_x", cx[0], 105);
      chk("drop_y", cy[0], 105);
      chk("drop_left", lb[0], 0);
      chk("drop_moved", mv[0], 0);
      chk("drop_ready", rdy[0], 0);
      recenter = 1'b0;
      repeat (3) @(negedge Clk);
      chk("drop_x_later", cx[0], 105);
      chk("drop_left_later", lb[0], 0);
      model_home();

      // asynchronous reset in the middle of a packet
      send(8'h08, 8'h00, 8'h14);
      wait_ready();
      byte1 = 8'h09;
      byte3 = 8'h32;
      pkt_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      pkt_valid = 1'b0;
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("arst_x", cx[0], 105);
      chk("arst_left", lb[0], 0);
      chk("arst_ready", rdy[0], 1);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      chk("arst_x_later", cx[0], 105);
      chk("arst_left_later", lb[0], 0);
      model_home();
      mbtn = 3'b000;

      // randomized packets against the model, with occasional recenter
      for (int i = 0; i < 60; i++) begin
         r1 = 8'($urandom);
         r1[3] = 1'b1;
         if ($urandom_range(0, 3) != 0) r1[7:6] = 2'b00;
         r2 = 8'($urandom);
         r3 = 8'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            r2 = {4'h0, r2[3:0]};
            r3 = {4'h0, r3[3:0]};
         end
         send(r1, r2, r3);
         if ($urandom_range(0, 9) == 0) begin
            recenter = 1'b1;
            @(negedge Clk);
            recenter = 1'b0;
            model_home();
            chk("rand_recenter_x", cx[1], 105);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
